// File: rtl/if_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// if_prefetch_pkg
//   Shared fetch definitions for the instruction prefetch unit: boot PC,
//   instruction queue entry layout and the request state encodings.
//   No ports (package).
// ----------------------------------------------------------------------------
package if_prefetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

    // Queue entry is {pc, inst}; the PC sits in the upper half.
    localparam int Q_ENTRY_W = 64;
    localparam int PC_LSB    = 32;
    localparam int INST_LSB  = 0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

endpackage

// File: rtl/if_prefetch_fifo.sv
// ----------------------------------------------------------------------------
// if_prefetch_fifo
//   Small synchronous FIFO used as the in-flight tag queue of the prefetcher.
//   With BYPASS set, a push into an empty FIFO is visible on pop_data in the
//   same cycle, and a simultaneous pop consumes it without storing it.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     push, push_data     write strobe and data
//     pop, pop_data       read strobe and head data (or bypassed push data)
// ----------------------------------------------------------------------------
module if_prefetch_fifo #(
    parameter int WIDTH         = 32,
    parameter int DEEP_SIZE     = 1,
    parameter int BYPASS        = 1,
    parameter int RETIRE_MEM_EN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data
);

    localparam int DEPTH = 1 << DEEP_SIZE;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEEP_SIZE-1:0] wr_ptr;
    logic [DEEP_SIZE-1:0] rd_ptr;
    logic [DEEP_SIZE:0]   count;
    logic                 empty;
    logic                 bypass;
    logic                 do_write;
    logic                 do_read;

    assign empty    = (count == '0);
    assign bypass   = (BYPASS != 0) && empty && push;
    // A bypassed entry that is popped in the same cycle never lands in memory.
    assign do_write = push && !(bypass && pop);
    assign do_read  = pop && !empty;
    assign pop_data = bypass ? push_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + DEEP_SIZE'(1);
            if (do_read)  rd_ptr <= rd_ptr + DEEP_SIZE'(1);
            count <= count + (DEEP_SIZE + 1)'(do_write) - (DEEP_SIZE + 1)'(do_read);
        end
    end

    // Storage carries no reset; optionally scrub entries as they retire.
    always_ff @(posedge clk) begin
        if ((RETIRE_MEM_EN != 0) && do_read) mem[rd_ptr] <= '0;
        if (do_write) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_prefetch.sv
// ----------------------------------------------------------------------------
// if_prefetch
//   Fetch-side producer for the instruction queue. Issues sequential word
//   fetches on an sram-like icache port and pushes {pc, inst} entries into the
//   downstream queue. Queue occupancy plus live in-flight requests never
//   exceed the queue depth. A redirect flushes the queue and silently drops
//   every response belonging to a request made before the redirect.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     redirect_valid, redirect_pc     one-cycle redirect and new fetch PC
//     inst_req, inst_addr             icache request and address
//     inst_addr_ok                    request accepted this cycle
//     inst_data_ok, inst_rdata        in-order response and instruction
//     q_write, q_wdata                queue push strobe and {pc, inst}
//     q_read                          queue pop by decode (observed only)
//     q_clear                         queue flush
// ----------------------------------------------------------------------------
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          Q_DEEP_SIZE = 4,
    parameter int          OST_SIZE    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 inst_req,
    output logic [31:0]          inst_addr,
    input  logic                 inst_addr_ok,
    input  logic                 inst_data_ok,
    input  logic [31:0]          inst_rdata,
    output logic                 q_write,
    output logic [Q_ENTRY_W-1:0] q_wdata,
    input  logic                 q_read,
    output logic                 q_clear
);

    localparam int QW = Q_DEEP_SIZE + 1;
    localparam int OW = OST_SIZE + 1;
    localparam int BW = QW + 1;
    localparam logic [BW-1:0] QD      = BW'(1 << Q_DEEP_SIZE);
    localparam logic [OW-1:0] MAX_OST = OW'(1 << OST_SIZE);

    logic [0:0]    state;
    logic [31:0]   pc;
    logic [31:0]   req_addr;
    logic [31:0]   tag_pc;
    logic [OW-1:0] ost_cnt;
    logic [OW-1:0] cancel_cnt;
    logic [OW-1:0] ost_next;
    logic [OW-1:0] cancel_next;
    logic [QW-1:0] q_cnt;
    logic [BW-1:0] budget;
    logic          kill_pend;
    logic          accept;
    logic          stale_hit;
    logic          issue;

    assign inst_req  = (state == S_REQ);
    assign inst_addr = req_addr;
    assign accept    = inst_req && inst_addr_ok;
    assign q_clear   = redirect_valid;

    // Slots already promised to the queue: stored entries plus live requests.
    assign budget = BW'(q_cnt) + BW'(ost_cnt - cancel_cnt);
    assign issue  = (state == S_IDLE) && !redirect_valid
                 && (ost_cnt < MAX_OST) && (budget < QD);

    // The head response is stale if older cancelled requests remain, or if a
    // killed request is accepted and bypassed straight back with nothing ahead.
    assign stale_hit = (cancel_cnt != '0) || (accept && kill_pend && (ost_cnt == '0));

    assign q_write = inst_data_ok && !stale_hit && !redirect_valid;
    assign q_wdata[PC_LSB +: 32]   = tag_pc;
    assign q_wdata[INST_LSB +: 32] = inst_rdata;

    assign ost_next    = ost_cnt + OW'(accept) - OW'(inst_data_ok);
    // On redirect everything still in flight after this edge becomes stale.
    assign cancel_next = redirect_valid ? ost_next
                       : cancel_cnt + OW'(accept && kill_pend)
                                    - OW'(inst_data_ok && stale_hit);

    // Request FSM, PC generation and bookkeeping counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            ost_cnt    <= '0;
            cancel_cnt <= '0;
            q_cnt      <= '0;
            kill_pend  <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                if (issue) begin
                    state    <= S_REQ;
                    req_addr <= pc;
                end
            end else if (inst_addr_ok) begin
                state <= S_IDLE;
            end

            if (redirect_valid) begin
                pc <= redirect_pc & 32'hffff_fffc;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            // The held request cannot be withdrawn, so remember to drop it.
            if (accept) begin
                kill_pend <= 1'b0;
            end else if (redirect_valid && inst_req) begin
                kill_pend <= 1'b1;
            end

            ost_cnt    <= ost_next;
            cancel_cnt <= cancel_next;

            if (redirect_valid) begin
                q_cnt <= '0;
            end else begin
                q_cnt <= q_cnt + QW'(q_write) - QW'(q_read);
            end
        end
    end

    if_prefetch_fifo #(
        .WIDTH        (32),
        .DEEP_SIZE    (OST_SIZE),
        .BYPASS       (1),
        .RETIRE_MEM_EN(0)
    ) tag_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_data(req_addr),
        .pop      (inst_data_ok),
        .pop_data (tag_pc)
    );

endmodule

// File: tb/tb_if_prefetch.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch
//   Self-checking bench for if_prefetch. A transaction-level model tracks the
//   expected fetch PC, the list of outstanding requests with a stale flag each,
//   and the queue occupancy; the icache and decode sides are driven randomly
//   or by directed sequences.
// ----------------------------------------------------------------------------
module tb_if_prefetch;

    localparam logic [31:0] BOOT_PC = 32'hbfc00000;
    localparam int QD      = 16;
    localparam int MAX_OST = 2;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        q_write;
    logic [63:0] q_wdata;
    logic        q_read;
    logic        q_clear;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } tx_t;

    tx_t         tx_q[$];
    logic [31:0] acc_log[$];
    logic [63:0] wr_log[$];
    logic [31:0] mpc;
    logic [31:0] pend_addr;
    bit          exp_req;
    bit          pend_stale;
    int          occ;
    int          checks;
    int          failures;
    int          dut_writes;
    bit          last_qw;

    if_prefetch #(
        .RESET_PC   (BOOT_PC),
        .Q_DEEP_SIZE(4),
        .OST_SIZE   (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .q_write       (q_write),
        .q_wdata       (q_wdata),
        .q_read        (q_read),
        .q_clear       (q_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        mpc        = BOOT_PC;
        pend_addr  = BOOT_PC;
        exp_req    = 1'b0;
        pend_stale = 1'b0;
        occ        = 0;
    endtask

    task automatic drive_idle();
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        q_read         = 1'b0;
    endtask

    // Synchronous reset for one edge, then check the reset-state outputs.
    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("rst_inst_req", 64'(inst_req), 64'(0));
        check_output("rst_q_write", 64'(q_write), 64'(0));
        check_output("rst_q_clear", 64'(q_clear), 64'(0));
        check_output("rst_inst_addr", 64'(inst_addr), 64'(BOOT_PC));
        model_reset();
    endtask

    // One clock cycle: drive inputs (kept protocol-legal), check the outputs
    // against the model, then advance the model across the clock edge.
    task automatic apply_stimulus(input bit a_ok, input bit d_ok, input logic [31:0] rdata,
                                  input bit redir, input logic [31:0] rpc, input bit qrd);
        tx_t front;
        tx_t nt;
        bit  acc;
        bit  dok;
        bit  qr;
        bit  exp_w;
        int  ost;
        int  live;
        int  occ_pre;

        acc = exp_req && a_ok;
        dok = d_ok && ((tx_q.size() > 0) || acc);
        qr  = qrd && (occ > 0);
        inst_addr_ok   = acc;
        inst_data_ok   = dok;
        inst_rdata     = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        q_read         = qr;
        #1;

        if (tx_q.size() > 0) begin
            front = tx_q[0];
        end else begin
            front.addr  = pend_addr;
            front.stale = pend_stale;
        end
        exp_w = dok && !front.stale && !redir;

        check_output("inst_req", 64'(inst_req), 64'(exp_req));
        if (exp_req) check_output("inst_addr", 64'(inst_addr), 64'(pend_addr));
        check_output("q_clear", 64'(q_clear), 64'(redir));
        check_output("q_write", 64'(q_write), 64'(exp_w));
        if (exp_w) check_output("q_wdata", q_wdata, {front.addr, rdata});
        check_output("q_write_when_full", 64'(q_write && (occ >= QD)), 64'(0));

        last_qw = q_write;
        if (q_write) begin
            dut_writes++;
            wr_log.push_back(q_wdata);
        end
        if (acc) acc_log.push_back(inst_addr);

        ost  = tx_q.size();
        live = 0;
        foreach (tx_q[i]) if (!tx_q[i].stale) live++;
        occ_pre = occ;

        if (acc) begin
            nt.addr  = pend_addr;
            nt.stale = pend_stale || redir;
            tx_q.push_back(nt);
        end
        if (dok) void'(tx_q.pop_front());
        if (redir) foreach (tx_q[i]) tx_q[i].stale = 1'b1;
        occ = redir ? 0 : occ + int'(exp_w) - int'(qr);

        if (exp_req) begin
            if (acc) exp_req = 1'b0;
            else if (redir) pend_stale = 1'b1;
        end else if (!redir && (ost < MAX_OST) && (occ_pre + live < QD)) begin
            exp_req    = 1'b1;
            pend_addr  = mpc;
            pend_stale = 1'b0;
            mpc        = mpc + 32'd4;
        end
        if (redir) mpc = rpc & 32'hffff_fffc;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n, input int a_pct, input int d_pct,
                              input int r_pct, input int redir_pct);
        for (int i = 0; i < n; i++) begin
            apply_stimulus($urandom_range(99) < a_pct, $urandom_range(99) < d_pct, $urandom,
                           $urandom_range(99) < redir_pct, $urandom, $urandom_range(99) < r_pct);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        dut_writes = 0;
        last_qw    = 1'b0;
        reset      = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Sequential fetch with an always-ready icache.
        do_reset();
        acc_log.delete();
        wr_log.delete();
        run_cycles(12, 100, 100, 0, 0);
        check_output("seq_addr0", 64'(acc_log[0]), 64'(32'hbfc00000));
        check_output("seq_addr1", 64'(acc_log[1]), 64'(32'hbfc00004));
        check_output("seq_addr2", 64'(acc_log[2]), 64'(32'hbfc00008));
        check_output("seq_wpc0", 64'(wr_log[0][63:32]), 64'(32'hbfc00000));
        check_output("seq_wpc1", 64'(wr_log[1][63:32]), 64'(32'hbfc00004));

        // Queue fills to exactly its depth, then one pop frees one fetch.
        do_reset();
        dut_writes = 0;
        run_cycles(60, 100, 100, 0, 0);
        check_output("full_writes", 64'(dut_writes), 64'(16));
        check_output("full_no_req", 64'(inst_req), 64'(0));
        acc_log.delete();
        apply_stimulus(1'b1, 1'b1, $urandom, 1'b0, '0, 1'b1);
        run_cycles(20, 100, 100, 0, 0);
        check_output("pop_one_req", 64'(acc_log.size()), 64'(1));
        check_output("pop_one_write", 64'(dut_writes), 64'(17));

        // Redirect with two requests in flight.
        do_reset();
        acc_log.delete();
        run_cycles(5, 100, 0, 0, 0);
        check_output("redir_ost2", 64'(acc_log.size()), 64'(2));
        apply_stimulus(1'b0, 1'b0, $urandom, 1'b1, 32'h80001003, 1'b0);
        acc_log.delete();
        wr_log.delete();
        apply_stimulus(1'b0, 1'b0, $urandom, 1'b0, '0, 1'b0);
        check_output("redir_clear_pulse", 64'(q_clear), 64'(0));
        run_cycles(12, 100, 100, 0, 0);
        check_output("redir_new_addr", 64'(acc_log[0]), 64'(32'h80001000));
        check_output("redir_first_wpc", 64'(wr_log[0][63:32]), 64'(32'h80001000));

        // Redirect while a request is held without acceptance.
        do_reset();
        apply_stimulus(1'b0, 1'b0, $urandom, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, 1'b0, $urandom, 1'b1, 32'h00400002, 1'b0);
        apply_stimulus(1'b0, 1'b0, $urandom, 1'b0, '0, 1'b0);
        check_output("held_req", 64'(inst_req), 64'(1));
        check_output("held_addr", 64'(inst_addr), 64'(BOOT_PC));
        acc_log.delete();
        wr_log.delete();
        run_cycles(12, 100, 100, 0, 0);
        check_output("held_acc_old", 64'(acc_log[0]), 64'(BOOT_PC));
        check_output("held_acc_new", 64'(acc_log[1]), 64'(32'h00400000));
        check_output("held_first_wpc", 64'(wr_log[0][63:32]), 64'(32'h00400000));

        // Redirect in the same cycle as a response.
        do_reset();
        run_cycles(5, 100, 0, 0, 0);
        wr_log.delete();
        apply_stimulus(1'b0, 1'b1, $urandom, 1'b1, 32'h12345678, 1'b0);
        check_output("same_cycle_drop", 64'(last_qw), 64'(0));
        run_cycles(12, 100, 100, 0, 0);
        check_output("same_cycle_first_wpc", 64'(wr_log[0][63:32]), 64'(32'h12345678));

        // Reset in the middle of traffic with a partly filled queue.
        do_reset();
        dut_writes = 0;
        for (int i = 0; i < 60; i++) begin
            if (dut_writes >= 5 && tx_q.size() == 2) break;
            apply_stimulus(1'b1, dut_writes < 5, $urandom, 1'b0, '0, 1'b0);
        end
        check_output("mid_q_cnt", 64'(dut_writes), 64'(5));
        do_reset();
        dut_writes = 0;
        acc_log.delete();
        run_cycles(60, 100, 100, 0, 0);
        check_output("mid_boot_addr", 64'(acc_log[0]), 64'(BOOT_PC));
        check_output("mid_full_writes", 64'(dut_writes), 64'(16));

        // Randomized traffic against the model.
        do_reset();
        run_cycles(3000, 60, 50, 40, 3);
        run_cycles(1500, 80, 70, 10, 1);
        run_cycles(1500, 30, 30, 60, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
